tournament_table_scheduler: RTL and testbench

Sequencer and arbiter for the shared single-port pattern/choice counter tables of the tournament branch predictor. Fetch-side prediction lookups and retire-side training updates compete for one table port. Updates are queued and applied as read-then-write pairs. The block owns the speculative global path history and repairs it on mispredict.

---
 rtl/tournament_table_scheduler.sv | 164 ++++++++++++++++
 tb/tb_tournament_table_scheduler.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/tournament_table_scheduler.sv
// Port sequencer for the tournament predictor's single-port counter tables: arbitrates
// fetch lookups against queued training updates and owns the speculative history.
// Optional build macro TOURN_SCHED_STARVE_EN enables the starvation counter.
module tournament_table_scheduler #(
  parameter int HIST_W     = 12,
  parameter int QDEPTH     = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       pred_req,
  output logic                       pred_ready,
  output logic                       pred_valid,
  output logic                       pred_taken,
  output logic [HIST_W-1:0]          pred_index,
  input  logic                       upd_valid,
  output logic                       upd_ready,
  input  logic                       upd_taken,
  input  logic [HIST_W-1:0]          upd_index,
  input  logic                       upd_mispredict,
  output logic                       tbl_en,
  output logic                       tbl_we,
  output logic [HIST_W-1:0]          tbl_addr,
  output logic                       tbl_taken,
  input  logic                       tbl_pred,
  output logic [HIST_W-1:0]          hist,
  output logic [$clog2(QDEPTH):0]    q_count
);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, PRED_WAIT = 2'd1, UPD_WR = 2'd2} state_t;

  state_t             state;
  logic [HIST_W-1:0]  q_index [QDEPTH];
  logic [QDEPTH-1:0]  q_taken;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               not_empty;
  logic               starved;
  logic               grant_pred;
  logic               grant_upd;
  logic               push;
  logic               pop;

  assign full      = (count == CNT_W'(QDEPTH));
  assign not_empty = (count != '0);
  assign upd_ready = !full;
  assign q_count   = count;
  assign push      = upd_valid && !full;
  assign pop       = (state == UPD_WR);

`ifdef TOURN_SCHED_STARVE_EN
  localparam int SC_W = $clog2(STARVE_MAX + 1);
  logic [SC_W-1:0] starve_cnt;

  assign starved = (starve_cnt == SC_W'(STARVE_MAX)) && not_empty;

  // Counts prediction grants taken while updates wait; cleared when an update issues.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant_upd) begin
      starve_cnt <= '0;
    end else if (grant_pred && not_empty && (starve_cnt != SC_W'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + SC_W'(1);
    end
  end
`else
  assign starved = 1'b0;
`endif

  // Grant is gated by reset so nothing reaches the table while reset is held.
  always_comb begin
    grant_pred = 1'b0;
    grant_upd  = 1'b0;
    if (state == IDLE && !reset) begin
      if (full || starved) begin
        grant_upd = 1'b1;
      end else if (pred_req) begin
        grant_pred = 1'b1;
      end else if (not_empty) begin
        grant_upd = 1'b1;
      end else begin
        grant_upd = 1'b0;
      end
    end else begin
      grant_pred = 1'b0;
    end
  end

  always_comb begin
    pred_ready = grant_pred;
    pred_valid = (state == PRED_WAIT);
    pred_taken = (state == PRED_WAIT) && tbl_pred;
    tbl_en     = grant_pred || grant_upd || (state == UPD_WR);
    tbl_we     = (state == UPD_WR);
    tbl_taken  = (state == UPD_WR) && q_taken[rd_ptr];
    if (grant_pred) begin
      tbl_addr = hist;
    end else if (grant_upd || (state == UPD_WR)) begin
      tbl_addr = q_index[rd_ptr];
    end else begin
      tbl_addr = '0;
    end
  end

  // Queue payload storage; contents are don't-care until pushed.
  always_ff @(posedge clock) begin
    if (push) begin
      q_index[wr_ptr] <= upd_index;
      q_taken[wr_ptr] <= upd_taken;
    end
  end

  // Sequencer, queue pointers and speculative history.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      hist       <= '0;
      pred_index <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_pred) begin
            pred_index <= hist;
            state      <= PRED_WAIT;
          end else if (grant_upd) begin
            state <= UPD_WR;
          end
        end
        PRED_WAIT: state <= IDLE;
        UPD_WR: begin
          rd_ptr <= rd_ptr + PTR_W'(1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      // A mispredict repair wins over the shift of a completing prediction.
      if (push && upd_mispredict) begin
        hist <= {upd_index[HIST_W-2:0], upd_taken};
      end else if (state == PRED_WAIT) begin
        hist <= {hist[HIST_W-2:0], tbl_pred};
      end
    end
  end

endmodule

// File: tb/tb_tournament_table_scheduler.sv
// Self-checking bench for tournament_table_scheduler: directed steps then random traffic,
// all compared against a queue-based reference model of the arbitration rules.
module tb_tournament_table_scheduler;
  localparam int HW = 12;
  localparam int QD = 4;
  localparam int SM = 3;
`ifdef TOURN_SCHED_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic          clock;
  logic          reset;
  logic          pred_req;
  logic          pred_ready;
  logic          pred_valid;
  logic          pred_taken;
  logic [HW-1:0] pred_index;
  logic          upd_valid;
  logic          upd_ready;
  logic          upd_taken;
  logic [HW-1:0] upd_index;
  logic          upd_mispredict;
  logic          tbl_en;
  logic          tbl_we;
  logic [HW-1:0] tbl_addr;
  logic          tbl_taken;
  logic          tbl_pred;
  logic [HW-1:0] hist;
  logic [2:0]    q_count;

  int vectors = 0;
  int errors  = 0;

  // Reference model: pending updates as a queue of {taken, index}
  logic [HW:0]   mq[$];
  int            m_phase;   // 0 free, 1 prediction returning, 2 write-back
  logic [HW-1:0] m_hist;
  logic [HW-1:0] m_pidx;
  int            m_starve;

  tournament_table_scheduler #(.HIST_W(HW), .QDEPTH(QD), .STARVE_MAX(SM)) dut (
    .clock(clock), .reset(reset),
    .pred_req(pred_req), .pred_ready(pred_ready), .pred_valid(pred_valid),
    .pred_taken(pred_taken), .pred_index(pred_index),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_taken(upd_taken),
    .upd_index(upd_index), .upd_mispredict(upd_mispredict),
    .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_taken(tbl_taken),
    .tbl_pred(tbl_pred), .hist(hist), .q_count(q_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_phase  = 0;
    m_hist   = '0;
    m_pidx   = '0;
    m_starve = 0;
  endtask

  // One clock cycle: drive inputs, check every output mid-cycle, advance the model.
  task automatic tick(input logic preq, input logic uv, input logic ut,
                      input logic [HW-1:0] ui, input logic um, input logic tp);
    int sz;
    bit gp, gu, force_u, acc;
    logic e_en, e_we, e_tk, e_pv, e_pt;
    logic [HW-1:0] e_addr;
    pred_req = preq; upd_valid = uv; upd_taken = ut;
    upd_index = ui; upd_mispredict = um; tbl_pred = tp;
    @(negedge clock);
    sz = mq.size();
    force_u = (sz == QD) || (STARVE_ON && m_starve == SM && sz > 0);
    gp = 1'b0; gu = 1'b0;
    e_en = 1'b0; e_we = 1'b0; e_tk = 1'b0; e_pv = 1'b0; e_pt = 1'b0; e_addr = '0;
    if (m_phase == 0) begin
      if (force_u) gu = 1'b1;
      else if (preq) gp = 1'b1;
      else if (sz > 0) gu = 1'b1;
      if (gp) begin e_en = 1'b1; e_addr = m_hist; end
      if (gu) begin e_en = 1'b1; e_addr = mq[0][HW-1:0]; end
    end else if (m_phase == 1) begin
      e_pv = 1'b1; e_pt = tp;
    end else begin
      e_en = 1'b1; e_we = 1'b1; e_addr = mq[0][HW-1:0]; e_tk = mq[0][HW];
    end
    chk("pred_ready", 32'(pred_ready), 32'(gp));
    chk("pred_valid", 32'(pred_valid), 32'(e_pv));
    chk("pred_taken", 32'(pred_taken), 32'(e_pt));
    chk("pred_index", 32'(pred_index), 32'(m_pidx));
    chk("upd_ready",  32'(upd_ready),  32'(sz < QD));
    chk("tbl_en",     32'(tbl_en),     32'(e_en));
    chk("tbl_we",     32'(tbl_we),     32'(e_we));
    chk("tbl_addr",   32'(tbl_addr),   32'(e_addr));
    chk("tbl_taken",  32'(tbl_taken),  32'(e_tk));
    chk("hist",       32'(hist),       32'(m_hist));
    chk("q_count",    32'(q_count),    32'(sz));
    acc = uv && (sz < QD);
    if (gp) m_pidx = m_hist;
    if (acc && um) m_hist = {ui[HW-2:0], ut};
    else if (m_phase == 1) m_hist = {m_hist[HW-2:0], tp};
    if (gu) m_starve = 0;
    else if (gp && sz > 0 && m_starve < SM) m_starve++;
    if (m_phase == 2) void'(mq.pop_front());
    if (acc) mq.push_back({ut, ui});
    m_phase = gp ? 1 : (gu ? 2 : 0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; pred_req = 1'b1; upd_valid = 1'b0; upd_taken = 1'b0;
    upd_index = '0; upd_mispredict = 1'b0; tbl_pred = 1'b0;
    model_reset();
    #2;
    chk("rst_pred_ready", 32'(pred_ready), 32'd0);
    chk("rst_tbl_en",     32'(tbl_en),     32'd0);
    chk("rst_upd_ready",  32'(upd_ready),  32'd1);
    chk("rst_hist",       32'(hist),       32'd0);
    chk("rst_q_count",    32'(q_count),    32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Prediction stream from hist=0 with tbl_pred=1
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
    chk("hist_after_preds", 32'(hist), 32'h003);

    // Single update with no prediction traffic
    tick(1'b0, 1'b1, 1'b1, 12'h0A5, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    chk("single_upd_drained", 32'(q_count), 32'd0);

    // Prediction pressure with four updates arriving back to back
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, i[0], 12'(12'h100 + i), 1'b0, i[1]);
    for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, i[0]);

    // Overfill attempts under prediction pressure
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b1, 12'(12'h200 + i), 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);

    // Mispredict repair colliding with a returning prediction
    tick(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 12'h7FF, 1'b1, 1'b1);
    chk("repair_hist", 32'(hist), 32'hFFE);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);

    // Reset asserted while a write-back is on the port
    tick(1'b0, 1'b1, 1'b1, 12'h155, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    chk("pre_reset_we", 32'(tbl_we), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_tbl_en",  32'(tbl_en),  32'd0);
    chk("mid_rst_q_count", 32'(q_count), 32'd0);
    chk("mid_rst_hist",    32'(hist),    32'd0);
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom),
           12'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
